cvxif_result_buffer: RTL and testbench

- Writeback stage directly downstream of the posit arithmetic coprocessor (PAU) on the CV-X-IF path.
- Snoops accepted issue transactions and queues each instruction's id and rd in a tag FIFO.
- Pairs each PAU result with the oldest queued tag and buffers the combined entry in a result FIFO.
- Drives the core-facing CV-X-IF result channel (id, rd, we, data) under a valid/ready handshake, so the PAU is decoupled from core writeback back-pressure.

---
 rtl/cvxif_result_buffer.sv | 102 ++++++++++
 tb/tb_cvxif_result_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_result_buffer.sv
// CV-X-IF writeback buffer: pairs PAU results with queued issue tags (id, rd)
// and presents them in order on the core-facing result channel.
module cvxif_result_buffer #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_fire,
    input  logic [ID_W-1:0] issue_id,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    input  logic            pau_result_valid,
    output logic            pau_result_ready,
    input  logic [XLEN-1:0] pau_result_data,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [ID_W-1:0] result_id,
    output logic [4:0]      result_rd,
    output logic            result_we,
    output logic [XLEN-1:0] result_data,
    output logic            tag_overflow,
    output logic            orphan_result
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int TAG_W = ID_W + 5;
    localparam int RES_W = TAG_W + XLEN;

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [RES_W-1:0] res_mem [DEPTH];
    logic [PW-1:0]    tag_wr, tag_rd, res_wr, res_rd;

    logic tag_full, tag_empty, res_full, res_empty;
    logic tag_push, pau_fire, res_pop;
    logic [TAG_W-1:0] tag_head;
    logic [RES_W-1:0] res_head;

    // The extra pointer MSB distinguishes a full FIFO from an empty one.
    assign tag_full  = (tag_wr[AW-1:0] == tag_rd[AW-1:0]) && (tag_wr[AW] != tag_rd[AW]);
    assign tag_empty = (tag_wr == tag_rd);
    assign res_full  = (res_wr[AW-1:0] == res_rd[AW-1:0]) && (res_wr[AW] != res_rd[AW]);
    assign res_empty = (res_wr == res_rd);

    assign issue_stall      = tag_full;
    assign pau_result_ready = !tag_empty && !res_full;
    assign result_valid     = !res_empty;
    assign result_we        = result_valid;

    assign tag_push = issue_fire && !tag_full;
    assign pau_fire = pau_result_valid && pau_result_ready;
    assign res_pop  = result_valid && result_ready;

    assign tag_head = tag_mem[tag_rd[AW-1:0]];
    assign res_head = res_mem[res_rd[AW-1:0]];

    assign result_id   = res_head[RES_W-1 -: ID_W];
    assign result_rd   = res_head[XLEN +: 5];
    assign result_data = res_head[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[tag_wr[AW-1:0]] <= {issue_id, issue_rd};
                tag_wr <= tag_wr + 1'b1;
            end
            if (pau_fire) tag_rd <= tag_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_wr <= '0;
            res_rd <= '0;
            for (int i = 0; i < DEPTH; i++) res_mem[i] <= '0;
        end else begin
            if (pau_fire) begin
                res_mem[res_wr[AW-1:0]] <= {tag_head, pau_result_data};
                res_wr <= res_wr + 1'b1;
            end
            if (res_pop) res_rd <= res_rd + 1'b1;
        end
    end

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_overflow  <= 1'b0;
            orphan_result <= 1'b0;
        end else begin
            if (issue_fire && tag_full)        tag_overflow  <= 1'b1;
            if (pau_result_valid && tag_empty) orphan_result <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed self-checking bench for cvxif_result_buffer.
module tb_cvxif_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_fire;
    logic [3:0]  issue_id;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic        pau_result_valid;
    logic        pau_result_ready;
    logic [31:0] pau_result_data;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [31:0] result_data;
    logic        tag_overflow;
    logic        orphan_result;

    int nchk  = 0;
    int nfail = 0;

    cvxif_result_buffer #(.DEPTH(4), .ID_W(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .issue_fire(issue_fire), .issue_id(issue_id), .issue_rd(issue_rd),
        .issue_stall(issue_stall),
        .pau_result_valid(pau_result_valid), .pau_result_ready(pau_result_ready),
        .pau_result_data(pau_result_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_rd(result_rd), .result_we(result_we),
        .result_data(result_data),
        .tag_overflow(tag_overflow), .orphan_result(orphan_result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_fire = 1'b0; issue_id = '0; issue_rd = '0;
        pau_result_valid = 1'b0; pau_result_data = '0; result_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        nchk++;
        if ({issue_stall, pau_result_ready, result_valid, result_we} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b required 0000",
                     {issue_stall, pau_result_ready, result_valid, result_we});
            nfail++;
        end
        nchk++;
        if ({result_id, result_rd, result_data} !== 41'd0) begin
            $display("FAIL reset_data: got id=%h rd=%h data=%h required 0", result_id, result_rd, result_data);
            nfail++;
        end
        nchk++;
        if ({tag_overflow, orphan_result} !== 2'b00) begin
            $display("FAIL reset_flags: got %b required 00", {tag_overflow, orphan_result});
            nfail++;
        end
    endtask

    task automatic test_single();
        issue_fire = 1'b1; issue_id = 4'd3; issue_rd = 5'd10;
        step();
        issue_fire = 1'b0;
        step();
        pau_result_valid = 1'b1; pau_result_data = 32'h0000_4000; result_ready = 1'b1;
        #1;
        nchk++;
        if (pau_result_ready !== 1'b1) begin
            $display("FAIL single_pau_ready: got %b required 1", pau_result_ready);
            nfail++;
        end
        nchk++;
        if (result_valid !== 1'b0) begin
            $display("FAIL single_no_bypass: got %b required 0", result_valid);
            nfail++;
        end
        step();
        pau_result_valid = 1'b0;
        #1;
        nchk++;
        if ({result_valid, result_we, result_id, result_rd, result_data} !== {1'b1, 1'b1, 4'd3, 5'd10, 32'h0000_4000}) begin
            $display("FAIL single_out: got v=%b we=%b id=%0d rd=%0d data=%h required v=1 we=1 id=3 rd=10 data=00004000",
                     result_valid, result_we, result_id, result_rd, result_data);
            nfail++;
        end
        step();
        nchk++;
        if ({result_valid, result_we} !== 2'b00) begin
            $display("FAIL single_drain: got v=%b we=%b required 0 0", result_valid, result_we);
            nfail++;
        end
        result_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic fire;
        result_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue_fire = 1'b1; issue_id = 4'(i); issue_rd = 5'(i + 16);
            step();
        end
        issue_fire = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pau_result_valid = 1'b1; pau_result_data = 32'(i * 32'h11);
            #1;
            nchk++;
            if (pau_result_ready !== 1'b1) begin
                $display("FAIL bp_fill_ready%0d: got %b required 1", i, pau_result_ready);
                nfail++;
            end
            step();
        end
        pau_result_valid = 1'b0;
        // A fifth tag gives the PAU something to pair with while the result FIFO is full.
        issue_fire = 1'b1; issue_id = 4'd5; issue_rd = 5'd21;
        step();
        issue_fire = 1'b0;
        pau_result_valid = 1'b1; pau_result_data = 32'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            nchk++;
            if ({pau_result_ready, result_valid, result_id, result_data} !== {1'b0, 1'b1, 4'd1, 32'h11}) begin
                $display("FAIL bp_hold%0d: got prdy=%b v=%b id=%0d data=%h required prdy=0 v=1 id=1 data=11",
                         c, pau_result_ready, result_valid, result_id, result_data);
                nfail++;
            end
            step();
        end
        result_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            nchk++;
            if ({result_valid, result_id, result_rd, result_data} !== {1'b1, 4'(k), 5'(k + 16), 32'(k * 32'h11)}) begin
                $display("FAIL bp_drain%0d: got v=%b id=%0d rd=%0d data=%h required v=1 id=%0d rd=%0d data=%h",
                         k, result_valid, result_id, result_rd, result_data, k, k + 16, k * 32'h11);
                nfail++;
            end
            fire = pau_result_valid && pau_result_ready;
            step();
            if (fire) pau_result_valid = 1'b0;
        end
        #1;
        nchk++;
        if ({result_valid, pau_result_valid, orphan_result, tag_overflow} !== 4'b0000) begin
            $display("FAIL bp_end: got v=%b pvld=%b orphan=%b ovf=%b required all 0",
                     result_valid, pau_result_valid, orphan_result, tag_overflow);
            nfail++;
        end
        idle_inputs();
    endtask

    task automatic test_tag_full();
        for (int i = 1; i <= 4; i++) begin
            #1;
            nchk++;
            if (issue_stall !== 1'b0) begin
                $display("FAIL tf_stall_pre%0d: got %b required 0", i, issue_stall);
                nfail++;
            end
            issue_fire = 1'b1; issue_id = 4'(i); issue_rd = 5'(i);
            step();
        end
        issue_fire = 1'b0;
        #1;
        nchk++;
        if ({issue_stall, tag_overflow} !== 2'b10) begin
            $display("FAIL tf_full: got stall=%b ovf=%b required stall=1 ovf=0", issue_stall, tag_overflow);
            nfail++;
        end
        issue_fire = 1'b1; issue_id = 4'd9; issue_rd = 5'd9;
        step();
        issue_fire = 1'b0;
        #1;
        nchk++;
        if ({issue_stall, tag_overflow} !== 2'b11) begin
            $display("FAIL tf_overflow: got stall=%b ovf=%b required 1 1", issue_stall, tag_overflow);
            nfail++;
        end
        result_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pau_result_valid = 1'b1; pau_result_data = 32'(i + 32'hA0);
            step();
            pau_result_valid = 1'b0;
            #1;
            nchk++;
            if ({result_valid, result_id, result_data} !== {1'b1, 4'(i), 32'(i + 32'hA0)}) begin
                $display("FAIL tf_drain%0d: got v=%b id=%0d data=%h required v=1 id=%0d data=%h",
                         i, result_valid, result_id, result_data, i, i + 32'hA0);
                nfail++;
            end
            step();
        end
        #1;
        nchk++;
        if ({result_valid, pau_result_ready, issue_stall, tag_overflow} !== 4'b0001) begin
            $display("FAIL tf_empty: got v=%b prdy=%b stall=%b ovf=%b required 0 0 0 1",
                     result_valid, pau_result_ready, issue_stall, tag_overflow);
            nfail++;
        end
        idle_inputs();
        do_reset();
        nchk++;
        if (tag_overflow !== 1'b0) begin
            $display("FAIL tf_ovf_clear: got %b required 0", tag_overflow);
            nfail++;
        end
    endtask

    task automatic test_orphan();
        pau_result_valid = 1'b1; pau_result_data = 32'hDEAD_BEEF;
        #1;
        nchk++;
        if (pau_result_ready !== 1'b0) begin
            $display("FAIL orphan_ready: got %b required 0", pau_result_ready);
            nfail++;
        end
        step();
        pau_result_valid = 1'b0;
        #1;
        nchk++;
        if ({orphan_result, result_valid} !== 2'b10) begin
            $display("FAIL orphan_flag: got orphan=%b v=%b required 1 0", orphan_result, result_valid);
            nfail++;
        end
        step();
        nchk++;
        if ({orphan_result, result_valid} !== 2'b10) begin
            $display("FAIL orphan_sticky: got orphan=%b v=%b required 1 0", orphan_result, result_valid);
            nfail++;
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        result_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            issue_fire = (c < 10); issue_id = 4'(c); issue_rd = 5'(c + 1);
            pau_result_valid = (c >= 1 && c <= 10);
            pau_result_data = 32'(32'h1000 + c - 1);
            #1;
            if (c >= 1 && c <= 10) begin
                nchk++;
                if (pau_result_ready !== 1'b1) begin
                    $display("FAIL b2b_prdy%0d: got %b required 1", c, pau_result_ready);
                    nfail++;
                end
            end
            if (c >= 2) begin
                nchk++;
                if ({result_valid, result_id, result_rd, result_data} !== {1'b1, 4'(c - 2), 5'(c - 1), 32'(32'h1000 + c - 2)}) begin
                    $display("FAIL b2b_out%0d: got v=%b id=%0d rd=%0d data=%h required v=1 id=%0d rd=%0d data=%h",
                             c, result_valid, result_id, result_rd, result_data, c - 2, c - 1, 32'h1000 + c - 2);
                    nfail++;
                end
            end
            nchk++;
            if (issue_stall !== 1'b0) begin
                $display("FAIL b2b_stall%0d: got %b required 0", c, issue_stall);
                nfail++;
            end
            step();
        end
        idle_inputs();
        #1;
        nchk++;
        if ({result_valid, tag_overflow, orphan_result} !== 3'b000) begin
            $display("FAIL b2b_end: got v=%b ovf=%b orphan=%b required 0 0 0",
                     result_valid, tag_overflow, orphan_result);
            nfail++;
        end
    endtask

    task automatic test_reset_mid();
        pau_result_valid = 1'b1;
        step();
        pau_result_valid = 1'b0;
        issue_fire = 1'b1; issue_id = 4'd7; issue_rd = 5'd7;
        step();
        issue_id = 4'd8; issue_rd = 5'd8;
        step();
        issue_fire = 1'b0;
        pau_result_valid = 1'b1; pau_result_data = 32'h77;
        step();
        pau_result_data = 32'h88;
        step();
        pau_result_valid = 1'b0;
        #1;
        nchk++;
        if ({result_valid, result_id, orphan_result} !== {1'b1, 4'd7, 1'b1}) begin
            $display("FAIL rm_queued: got v=%b id=%0d orphan=%b required 1 7 1", result_valid, result_id, orphan_result);
            nfail++;
        end
        do_reset();
        nchk++;
        if ({result_valid, issue_stall, pau_result_ready, tag_overflow, orphan_result} !== 5'b00000) begin
            $display("FAIL rm_cleared: got v=%b stall=%b prdy=%b ovf=%b orphan=%b required all 0",
                     result_valid, issue_stall, pau_result_ready, tag_overflow, orphan_result);
            nfail++;
        end
        issue_fire = 1'b1; issue_id = 4'd5; issue_rd = 5'd12;
        step();
        issue_fire = 1'b0;
        pau_result_valid = 1'b1; pau_result_data = 32'h0000_5555; result_ready = 1'b1;
        step();
        pau_result_valid = 1'b0;
        #1;
        nchk++;
        if ({result_valid, result_id, result_rd, result_data} !== {1'b1, 4'd5, 5'd12, 32'h0000_5555}) begin
            $display("FAIL rm_after: got v=%b id=%0d rd=%0d data=%h required v=1 id=5 rd=12 data=00005555",
                     result_valid, result_id, result_rd, result_data);
            nfail++;
        end
        step();
        nchk++;
        if (result_valid !== 1'b0) begin
            $display("FAIL rm_drain: got %b required 0", result_valid);
            nfail++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_tag_full();
        test_orphan();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
